mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one single-ported unified memory between the processor's instruction-fetch port and its data (load/store) port. Each requester issues a held request. The arbiter grants one transaction at a time and latches its command. It sequences the memory handshake and returns a one-cycle acknowledge with read data to the owner. Data accesses have priority; a starvation counter guarantees forward progress for fetch. It sits between the IF/MEM stages and the memory model, replacing their direct memory connections.

## Interface

- ADDR_W, 64, address width (both requesters and memory)
- DATA_W, 64, data width
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits (≥1)

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch read data, valid when i_ack=1
- i_ack  out  1  one-cycle completion pulse to fetch
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse to data port
- m_req  out  1  memory request, held until m_ack
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid when m_ack=1
- m_ack  in  1  memory completion; may be high in the first m_req cycle
- owner  out  1  0=fetch, 1=data; current or last grant
- busy  out  1  1 when state ≠ IDLE

## Operation

- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: if neither request is high, stay. Otherwise select a winner:
  - If only one request is high, that requester wins.
  - If both are high, data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - On a grant, latch addr, we and wdata into command registers (fetch forces we=0), set owner, and go to BUSY_I or BUSY_D.
- BUSY_x: m_req=1 and m_we/m_addr/m_wdata are driven from the command registers. Stay until m_ack=1. On m_ack, latch m_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
- RESP: pulse the owner's ack for exactly one cycle, then go to IDLE. Requests are ignored in RESP.
- Store completion: d_ack pulses; d_rdata holds its previous value.
- starve_cnt, width clog2(STARVE_LIMIT+1), updates at each grant in IDLE:
  - Data grant with i_req=1: increment, saturating at STARVE_LIMIT.
  - Data grant with i_req=0: clear to 0.
  - Fetch grant: clear to 0.
- Protocol rules for requesters:
  - Requesters drop req in the cycle after sampling ack.
  - If req drops while BUSY, the transaction still completes and ack still pulses.
  - Input changes after a grant are ignored; the latched command is used.
- m_req is never high outside BUSY_x; at most one outstanding memory transaction.
- i_rdata and d_rdata are registers that hold their value between acks.

## Timing

- All outputs are registered or decoded from state/command registers; no combinational path from inputs to outputs.
- Reset (asynchronous, reset_n=0) drives immediately:
  - state=IDLE
  - m_req=0, m_we=0, m_addr=0, m_wdata=0
  - i_ack=0, d_ack=0, i_rdata=0, d_rdata=0
  - owner=0, busy=0, starve_cnt=0
- Reset mid-transaction abandons it: no ack is issued, and m_req drops in the same cycle.
- Minimum latency: request sampled in IDLE at cycle N → m_req high in N+1 → with m_ack in N+1, ack in N+2 → next grant sampled at N+3. Peak throughput is one transaction per 3 cycles.
- Each memory wait cycle (m_ack=0 in BUSY) adds one cycle of latency.
- Simultaneous requests in IDLE resolve in the same cycle with no bubble.
- m_ack seen outside BUSY_x is ignored.

## Test plan

- Reset, then d_req=0 and i_req pulse at 0x100 with memory returning 0xDEAD on an immediate m_ack → m_addr=0x100 in cycle 1, i_ack=1 with i_rdata=0xDEAD in cycle 2, busy=0 in cycle 3.
- Store d_we=1, d_addr=0x2000, d_wdata=0x55AA with m_ack delayed 3 cycles → m_we=1 and m_wdata=0x55AA held for 4 cycles, d_ack pulses once, d_rdata unchanged.
- Both ports requesting continuously with STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I…; fetch is never delayed more than 4 data transactions.
- i_req alone at RESP time, d_req rising in RESP → i_ack pulses, then data is granted in the next IDLE cycle; no double grant; m_req is never high in RESP.
- reset_n asserted in BUSY_D with m_ack withheld → m_req, d_ack and busy go to 0 immediately. After release, the first new i_req completes normally with starve_cnt=0.
- m_ack pulsed while IDLE → no state change and no ack output.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port and the data (load/store) port. One transaction at a time, data
// has priority, and a starvation counter guarantees fetch forward progress.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // memory side
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  // status
  output logic              owner,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic                owner_q,      owner_d;
  logic                cmd_we_q,     cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q,   cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q,  cmd_wdata_d;
  logic [DATA_W-1:0]   i_rdata_q,    i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,    d_rdata_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                grant_data;

  // Next-state logic: arbitration in IDLE, memory handshake in BUSY, ack in RESP.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    starve_cnt_d = starve_cnt_q;
    // Data wins unless fetch is also waiting and has been passed over too often.
    grant_data   = d_req && !(i_req && (starve_cnt_q == LIMIT));

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (grant_data) begin
            owner_d     = 1'b1;
            cmd_we_d    = d_we;
            cmd_addr_d  = d_addr;
            cmd_wdata_d = d_wdata;
            state_d     = BUSY_D;
            if (!i_req) begin
              starve_cnt_d = '0;
            end else if (starve_cnt_q != LIMIT) begin
              starve_cnt_d = starve_cnt_q + CNT_ONE;
            end
          end else begin
            owner_d      = 1'b0;
            cmd_we_d     = 1'b0;
            cmd_addr_d   = i_addr;
            state_d      = BUSY_I;
            starve_cnt_d = '0;
          end
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          i_rdata_d = m_rdata;
          state_d   = RESP;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          // Stores leave the load data register untouched.
          if (!cmd_we_q) begin
            d_rdata_d = m_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; async reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Outputs decode only registered state, so nothing flows straight from inputs.
  always_comb begin
    m_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
    m_we    = cmd_we_q;
    m_addr  = cmd_addr_q;
    m_wdata = cmd_wdata_q;
    i_ack   = (state_q == RESP) && !owner_q;
    d_ack   = (state_q == RESP) &&  owner_q;
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
    owner   = owner_q;
    busy    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with hand-computed expectations
// for the fetch/data memory arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [63:0] i_addr;
  logic [63:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ack;
  logic        owner;
  logic        busy;

  int total  = 0;
  int passed = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_ack = 0;
    tick(); tick();
    total++;
    if ({m_req, m_we, i_ack, d_ack, owner, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {m_req, m_we, i_ack, d_ack, owner, busy});
    else passed++;
    total++;
    if ((m_addr | m_wdata | i_rdata | d_rdata) !== 64'h0)
      $display("FAIL reset_data: got addr=%h wdata=%h ir=%h dr=%h expected 0", m_addr, m_wdata, i_rdata, d_rdata);
    else passed++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_basic();
    i_req = 1; i_addr = 64'h100;
    tick();  // grant sampled, now BUSY_I
    total++;
    if (!(m_req === 1'b1 && m_addr === 64'h100 && m_we === 1'b0 && busy === 1'b1 && owner === 1'b0))
      $display("FAIL fetch_busy: got m_req=%b m_addr=%h m_we=%b busy=%b owner=%b expected 1 100 0 1 0",
               m_req, m_addr, m_we, busy, owner);
    else passed++;
    m_rdata = 64'hDEAD; m_ack = 1;
    tick();  // RESP
    total++;
    if (!(i_ack === 1'b1 && i_rdata === 64'hDEAD && d_ack === 1'b0 && m_req === 1'b0))
      $display("FAIL fetch_resp: got i_ack=%b i_rdata=%h d_ack=%b m_req=%b expected 1 dead 0 0",
               i_ack, i_rdata, d_ack, m_req);
    else passed++;
    i_req = 0; m_ack = 0; m_rdata = 64'h7777;
    tick();  // IDLE
    total++;
    if (!(busy === 1'b0 && i_ack === 1'b0 && i_rdata === 64'hDEAD))
      $display("FAIL fetch_idle: got busy=%b i_ack=%b i_rdata=%h expected 0 0 dead", busy, i_ack, i_rdata);
    else passed++;
  endtask

  task automatic test_load();
    d_req = 1; d_we = 0; d_addr = 64'h3000; d_wdata = 64'h0;
    tick();
    total++;
    if (!(m_req === 1'b1 && m_addr === 64'h3000 && m_we === 1'b0 && owner === 1'b1))
      $display("FAIL load_busy: got m_req=%b m_addr=%h m_we=%b owner=%b expected 1 3000 0 1",
               m_req, m_addr, m_we, owner);
    else passed++;
    m_rdata = 64'hBEEF; m_ack = 1;
    tick();
    total++;
    if (!(d_ack === 1'b1 && i_ack === 1'b0 && d_rdata === 64'hBEEF && i_rdata === 64'hDEAD))
      $display("FAIL load_resp: got d_ack=%b i_ack=%b d_rdata=%h i_rdata=%h expected 1 0 beef dead",
               d_ack, i_ack, d_rdata, i_rdata);
    else passed++;
    d_req = 0; m_ack = 0;
    tick();
  endtask

  task automatic test_store_wait();
    int acks;
    d_req = 1; d_we = 1; d_addr = 64'h2000; d_wdata = 64'h55AA;
    tick();  // BUSY_D
    // Inputs changing after the grant must not disturb the latched command.
    d_addr = 64'h4444; d_wdata = 64'h1111; d_we = 0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (!(m_req === 1'b1 && m_we === 1'b1 && m_wdata === 64'h55AA && m_addr === 64'h2000))
        $display("FAIL store_hold%0d: got m_req=%b m_we=%b m_wdata=%h m_addr=%h expected 1 1 55aa 2000",
                 k, m_req, m_we, m_wdata, m_addr);
      else passed++;
      if (d_ack === 1'b1) acks++;
      if (k == 3) begin m_ack = 1; m_rdata = 64'h9999; end
      tick();
    end
    if (d_ack === 1'b1) acks++;
    total++;
    if (!(d_ack === 1'b1 && d_rdata === 64'hBEEF && m_req === 1'b0))
      $display("FAIL store_resp: got d_ack=%b d_rdata=%h m_req=%b expected 1 beef 0", d_ack, d_rdata, m_req);
    else passed++;
    d_req = 0; m_ack = 0;
    tick();
    if (d_ack === 1'b1) acks++;
    tick();
    if (d_ack === 1'b1) acks++;
    total++;
    if (acks !== 1 || busy !== 1'b0)
      $display("FAIL store_ackcount: got acks=%0d busy=%b expected 1 0", acks, busy);
    else passed++;
  endtask

  // Both ports request continuously for n transactions; grant order follows pattern.
  task automatic both_requesting(input int n, input string tag);
    int exp_own [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    i_req = 1; i_addr = 64'hA0; d_req = 1; d_we = 0; d_addr = 64'hB0;
    for (int k = 0; k < n; k++) begin
      tick();  // BUSY
      total++;
      if (!(m_req === 1'b1 && owner === exp_own[k][0] &&
            m_addr === (exp_own[k] == 1 ? 64'hB0 : 64'hA0)))
        $display("FAIL %s_grant%0d: got m_req=%b owner=%b m_addr=%h expected owner=%0d",
                 tag, k, m_req, owner, m_addr, exp_own[k]);
      else passed++;
      m_ack = 1; m_rdata = 64'h1000 + 64'(k);
      tick();  // RESP
      total++;
      if (exp_own[k] == 1) begin
        if (!(d_ack === 1'b1 && i_ack === 1'b0 && d_rdata === 64'h1000 + 64'(k) && m_req === 1'b0))
          $display("FAIL %s_resp%0d: got d_ack=%b i_ack=%b d_rdata=%h m_req=%b expected 1 0 %h 0",
                   tag, k, d_ack, i_ack, d_rdata, m_req, 64'h1000 + 64'(k));
        else passed++;
      end else begin
        if (!(i_ack === 1'b1 && d_ack === 1'b0 && i_rdata === 64'h1000 + 64'(k) && m_req === 1'b0))
          $display("FAIL %s_resp%0d: got i_ack=%b d_ack=%b i_rdata=%h m_req=%b expected 1 0 %h 0",
                   tag, k, i_ack, d_ack, i_rdata, m_req, 64'h1000 + 64'(k));
        else passed++;
      end
      m_ack = 0;
      tick();  // IDLE
    end
    i_req = 0; d_req = 0;
    tick();
  endtask

  task automatic test_resp_handover();
    i_req = 1; i_addr = 64'h300; d_req = 0;
    tick();  // BUSY_I
    m_ack = 1; m_rdata = 64'hCAFE;
    tick();  // RESP
    total++;
    if (!(i_ack === 1'b1 && m_req === 1'b0 && i_rdata === 64'hCAFE))
      $display("FAIL handover_resp: got i_ack=%b m_req=%b i_rdata=%h expected 1 0 cafe", i_ack, m_req, i_rdata);
    else passed++;
    d_req = 1; d_we = 0; d_addr = 64'h500; m_ack = 0;
    tick();  // IDLE, requests in RESP were ignored
    total++;
    if (!(busy === 1'b0 && m_req === 1'b0 && i_ack === 1'b0 && d_ack === 1'b0))
      $display("FAIL handover_idle: got busy=%b m_req=%b i_ack=%b d_ack=%b expected 0 0 0 0",
               busy, m_req, i_ack, d_ack);
    else passed++;
    i_req = 0;
    tick();  // BUSY_D
    total++;
    if (!(m_req === 1'b1 && owner === 1'b1 && m_addr === 64'h500))
      $display("FAIL handover_grant: got m_req=%b owner=%b m_addr=%h expected 1 1 500", m_req, owner, m_addr);
    else passed++;
    m_ack = 1; m_rdata = 64'hF00D;
    tick();
    total++;
    if (!(d_ack === 1'b1 && i_ack === 1'b0 && d_rdata === 64'hF00D))
      $display("FAIL handover_dack: got d_ack=%b i_ack=%b d_rdata=%h expected 1 0 f00d", d_ack, i_ack, d_rdata);
    else passed++;
    d_req = 0; m_ack = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    // Data grant while fetch waits leaves the starvation counter at 1.
    i_req = 1; i_addr = 64'hA0; d_req = 1; d_we = 0; d_addr = 64'hB0;
    tick();  // BUSY_D
    m_ack = 0;
    tick();  // still BUSY_D
    total++;
    if (!(m_req === 1'b1 && owner === 1'b1 && busy === 1'b1))
      $display("FAIL rstmid_pre: got m_req=%b owner=%b busy=%b expected 1 1 1", m_req, owner, busy);
    else passed++;
    reset_n = 0; i_req = 0; d_req = 0;
    #1;
    total++;
    if (!(m_req === 1'b0 && d_ack === 1'b0 && busy === 1'b0))
      $display("FAIL rstmid_drop: got m_req=%b d_ack=%b busy=%b expected 0 0 0", m_req, d_ack, busy);
    else passed++;
    tick();
    reset_n = 1;
    tick();
    total++;
    if (!(d_ack === 1'b0 && i_ack === 1'b0 && busy === 1'b0))
      $display("FAIL rstmid_noack: got d_ack=%b i_ack=%b busy=%b expected 0 0 0", d_ack, i_ack, busy);
    else passed++;
    // A cleared counter gives four data grants before fetch again.
    both_requesting(5, "rstmid");
  endtask

  task automatic test_mack_idle();
    m_ack = 1; m_rdata = 64'h5A5A;
    tick(); tick();
    total++;
    if (!(busy === 1'b0 && m_req === 1'b0 && i_ack === 1'b0 && d_ack === 1'b0 &&
          i_rdata !== 64'h5A5A && d_rdata !== 64'h5A5A))
      $display("FAIL mack_idle: got busy=%b m_req=%b i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h expected idle, no capture",
               busy, m_req, i_ack, d_ack, i_rdata, d_rdata);
    else passed++;
    m_ack = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_load();
    test_store_wait();
    both_requesting(10, "starve");
    test_resp_handover();
    test_reset_mid();
    test_mack_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
